// File: rtl/riscv_mem_pkg.sv
// Shared encodings, FSM state type and latency limits for the data-memory responder.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/riscv_dmem_lane_align.sv
// Byte-lane steering for stores, lane extraction plus extension for loads, and alignment check.
module riscv_dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_lane_o,
    output logic [31:0] rdata_ext_o,
    output logic        misalign_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata_raw_i[{addr_lo_i, 3'b000} +: 8];
    assign rd_half = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];

    // Replicating the narrow data lets the mask alone pick the target lanes.
    always_comb begin
        wmask_o      = 4'b0000;
        wdata_lane_o = wdata_i;
        rdata_ext_o  = 32'd0;
        misalign_o   = 1'b0;
        unique case (size_i)
            SZ_BYTE: begin
                wmask_o      = 4'(4'b0001 << addr_lo_i);
                wdata_lane_o = {4{wdata_i[7:0]}};
                rdata_ext_o  = unsigned_i ? {24'd0, rd_byte}
                                          : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                wmask_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_lane_o = {2{wdata_i[15:0]}};
                rdata_ext_o  = unsigned_i ? {16'd0, rd_half}
                                          : {{16{rd_half[15]}}, rd_half};
                misalign_o   = addr_lo_i[0];
            end
            SZ_WORD: begin
                wmask_o      = 4'b1111;
                wdata_lane_o = wdata_i;
                rdata_ext_o  = rdata_raw_i;
                misalign_o   = (addr_lo_i != 2'b00);
            end
            default: begin
                wmask_o      = 4'b0000;
                wdata_lane_o = wdata_i;
                rdata_ext_o  = 32'd0;
                misalign_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Single-outstanding data-memory responder with programmable ack latency and
// byte/half/word access checking.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned LAT_EFF = (LATENCY < LAT_MIN) ? LAT_MIN :
                                      (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_EFF - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [31:0]        wdata_q;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               busy_q;

    logic [31:0]        mem_q [DEPTH];

    logic               accept_c;
    logic               resp_c;
    logic               range_err_c;
    logic               err_c;
    logic               wr_en_c;
    logic [ADDR_W-1:0]  idx_c;
    logic [31:0]        rdata_raw_c;
    logic [3:0]         wmask_c;
    logic [31:0]        wdata_lane_c;
    logic [31:0]        rdata_ext_c;
    logic               misalign_c;

    assign accept_c    = (state_q == IDLE) && req_i;
    assign resp_c      = (state_q == WAIT) && (cnt_q == '0);
    assign idx_c       = addr_q[ADDR_W+1:2];
    assign rdata_raw_c = mem_q[idx_c];
    assign range_err_c = ((addr_q >> (ADDR_W + 2)) != 32'd0);
    assign err_c       = (size_q == SZ_ILL) || misalign_c || range_err_c;
    // Reset on the would-be RESP edge must suppress the write as well.
    assign wr_en_c     = resp_c && we_q && !err_c && !reset;

    riscv_dmem_lane_align u_lane_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .unsigned_i   (uns_q),
        .wdata_i      (wdata_q),
        .rdata_raw_i  (rdata_raw_c),
        .wmask_o      (wmask_c),
        .wdata_lane_o (wdata_lane_c),
        .rdata_ext_o  (rdata_ext_c),
        .misalign_o   (misalign_c)
    );

    // State, counter, request latch and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= (state_d != IDLE);
            if (accept_c) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
                wdata_q <= wdata_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response values are produced only on the WAIT->RESP edge; zero otherwise.
    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'd0;
        if (resp_c) begin
            ack_d = 1'b1;
            err_d = err_c;
            if (!err_c && !we_q) begin
                rdata_d = rdata_ext_c;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= wdata_lane_c[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: three instances at latencies 2, 1 and 15.
module tb_riscv_dmem_responder;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, req2;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        ack0, ack1, ack2;
    logic        err0, err1, err2;
    logic        busy0, busy1, busy2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut0 (
        .clk_i(clk), .reset(reset), .req_i(req0), .we_i(we), .addr_i(addr),
        .size_i(size), .unsigned_i(uns), .wdata_i(wdata),
        .rdata_o(rdata0), .ack_o(ack0), .err_o(err0), .busy_o(busy0));

    riscv_dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .reset(reset), .req_i(req1), .we_i(we), .addr_i(addr),
        .size_i(size), .unsigned_i(uns), .wdata_i(wdata),
        .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .busy_o(busy1));

    riscv_dmem_responder #(.ADDR_W(10), .LATENCY(15)) u_dut2 (
        .clk_i(clk), .reset(reset), .req_i(req2), .we_i(we), .addr_i(addr),
        .size_i(size), .unsigned_i(uns), .wdata_i(wdata),
        .rdata_o(rdata2), .ack_o(ack2), .err_o(err2), .busy_o(busy2));

    function automatic logic ack_of(input int sel);
        return (sel == 0) ? ack0 : (sel == 1) ? ack1 : ack2;
    endfunction

    function automatic logic err_of(input int sel);
        return (sel == 0) ? err0 : (sel == 1) ? err1 : err2;
    endfunction

    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 0) ? rdata0 : (sel == 1) ? rdata1 : rdata2;
    endfunction

    // One handshake: lat = edges from acceptance to ack (-1 on timeout), ack_nx = ack one edge later.
    task automatic access(input int sel, input logic w, input logic [31:0] a,
                          input logic [1:0] sz, input logic u, input logic [31:0] wd,
                          output int lat, output logic ack_nx,
                          output logic [31:0] rd, output logic er);
        lat   = -1;
        rd    = 32'hxxxx_xxxx;
        er    = 1'bx;
        we    = w;
        addr  = a;
        size  = sz;
        uns   = u;
        wdata = wd;
        req0  = (sel == 0);
        req1  = (sel == 1);
        req2  = (sel == 2);
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (ack_of(sel) === 1'b1) begin
                lat = n - 1;
                rd  = rdata_of(sel);
                er  = err_of(sel);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        req2 = 1'b0;
        @(posedge clk); #1;
        ack_nx = ack_of(sel);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        we = 1'b0; addr = 32'd0; size = SZ_WORD; uns = 1'b0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ack0, ack1, ack2, err0, err1, err2, busy0, busy1, busy2} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 000000000",
                     {ack0, ack1, ack2, err0, err1, err2, busy0, busy1, busy2});
        end
        n_vec++;
        if ((rdata0 | rdata1 | rdata2) !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h/%h/%h required 0", rdata0, rdata1, rdata2);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw;
        int lat; logic anx; logic [31:0] rd; logic er;
        access(0, 1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEADBEEF, lat, anx, rd, er);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL st_word_lat: got %0d required 2", lat); end
        n_vec++; if (anx !== 1'b0) begin n_err++; $display("FAIL st_word_width: got %b required 0", anx); end
        n_vec++; if (er !== 1'b0 || rd !== 32'd0) begin n_err++; $display("FAIL st_word_resp: got err=%b rdata=%h required 0/0", er, rd); end
        access(0, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL ld_word_lat: got %0d required 2", lat); end
        n_vec++; if (anx !== 1'b0) begin n_err++; $display("FAIL ld_word_width: got %b required 0", anx); end
        n_vec++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld_word: got err=%b rdata=%h required 0/deadbeef", er, rd); end
    endtask

    task automatic test_sub_word_load;
        int lat; logic anx; logic [31:0] rd; logic er;
        access(0, 1'b0, 32'h13, SZ_BYTE, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'hFFFFFFDE) begin n_err++; $display("FAIL ld_byte_s: got %h required ffffffde", rd); end
        access(0, 1'b0, 32'h13, SZ_BYTE, 1'b1, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'h000000DE) begin n_err++; $display("FAIL ld_byte_u: got %h required 000000de", rd); end
        access(0, 1'b0, 32'h10, SZ_HALF, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'hFFFFBEEF) begin n_err++; $display("FAIL ld_half_s: got %h required ffffbeef", rd); end
        access(0, 1'b0, 32'h12, SZ_HALF, 1'b1, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'h0000DEAD) begin n_err++; $display("FAIL ld_half_u: got %h required 0000dead", rd); end
        access(0, 1'b0, 32'h11, SZ_BYTE, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'hFFFFFFBE || er !== 1'b0) begin n_err++; $display("FAIL ld_byte_lane1: got %h err=%b required ffffffbe/0", rd, er); end
    endtask

    task automatic test_sub_word_store;
        int lat; logic anx; logic [31:0] rd; logic er;
        access(0, 1'b1, 32'h12, SZ_HALF, 1'b0, 32'hAAAA1234, lat, anx, rd, er);
        n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL st_half_err: got %b required 0", er); end
        access(0, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'h1234BEEF) begin n_err++; $display("FAIL st_half_merge: got %h required 1234beef", rd); end
        access(0, 1'b1, 32'h11, SZ_BYTE, 1'b0, 32'hFFFFFF55, lat, anx, rd, er);
        access(0, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'h123455EF) begin n_err++; $display("FAIL st_byte_merge: got %h required 123455ef", rd); end
    endtask

    task automatic test_errors;
        int lat; logic anx; logic [31:0] rd; logic er;
        access(0, 1'b1, 32'h12, SZ_WORD, 1'b0, 32'h0BAD0BAD, lat, anx, rd, er);
        n_vec++; if (lat !== 2 || er !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL st_misalign: got lat=%0d err=%b rdata=%h required 2/1/0", lat, er, rd); end
        access(0, 1'b0, 32'h11, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL ld_misalign: got err=%b rdata=%h required 1/0", er, rd); end
        access(0, 1'b0, 32'h13, SZ_HALF, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL ld_half_odd: got err=%b rdata=%h required 1/0", er, rd); end
        access(0, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (er !== 1'b0 || rd !== 32'h123455EF) begin n_err++; $display("FAIL err_no_write: got err=%b rdata=%h required 0/123455ef", er, rd); end
        access(0, 1'b1, 32'h10, SZ_ILL, 1'b0, 32'h0, lat, anx, rd, er);
        n_vec++; if (er !== 1'b1 || lat !== 2) begin n_err++; $display("FAIL size_ill: got err=%b lat=%0d required 1/2", er, lat); end
        access(0, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'h123455EF) begin n_err++; $display("FAIL size_ill_no_write: got %h required 123455ef", rd); end
    endtask

    task automatic test_range;
        int lat; logic anx; logic [31:0] rd; logic er;
        access(0, 1'b0, 32'h1000, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL ld_oor: got err=%b rdata=%h required 1/0", er, rd); end
        access(0, 1'b1, 32'hFFC, SZ_WORD, 1'b0, 32'hA5A50001, lat, anx, rd, er);
        n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL st_top: got err=%b required 0", er); end
        access(0, 1'b0, 32'hFFC, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (er !== 1'b0 || rd !== 32'hA5A50001) begin n_err++; $display("FAIL ld_top: got err=%b rdata=%h required 0/a5a50001", er, rd); end
        access(0, 1'b1, 32'h8000_0000, SZ_BYTE, 1'b0, 32'h77, lat, anx, rd, er);
        n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL st_oor_hi: got err=%b required 1", er); end
        access(0, 1'b0, 32'h0, SZ_BYTE, 1'b1, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd === 32'h00000077) begin n_err++; $display("FAIL oor_aliased: got %h required not 00000077", rd); end
    endtask

    task automatic test_reset_abort;
        int lat; logic anx; logic [31:0] rd; logic er; logic seen;
        access(0, 1'b1, 32'h20, SZ_WORD, 1'b0, 32'h11223344, lat, anx, rd, er);
        // Abort during the first WAIT cycle.
        we = 1'b1; addr = 32'h20; size = SZ_WORD; uns = 1'b0; wdata = 32'hCAFEF00D;
        req0 = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL abort_busy_pre: got %b required 1", busy0); end
        reset = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (busy0 !== 1'b0 || ack0 !== 1'b0) begin n_err++; $display("FAIL abort_wait: got busy=%b ack=%b required 0/0", busy0, ack0); end
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (ack0 === 1'b1) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_ack: got %b required 0", seen); end
        // Abort on the edge that would enter RESP.
        req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (busy0 !== 1'b0 || ack0 !== 1'b0) begin n_err++; $display("FAIL abort_resp_edge: got busy=%b ack=%b required 0/0", busy0, ack0); end
        reset = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b0, 32'h20, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (rd !== 32'h11223344 || er !== 1'b0) begin n_err++; $display("FAIL abort_mem: got %h err=%b required 11223344/0", rd, er); end
    endtask

    task automatic test_latency_sweep;
        int lat; logic anx; logic [31:0] rd; logic er;
        access(1, 1'b1, 32'h40, SZ_WORD, 1'b0, 32'h0BADCAFE, lat, anx, rd, er);
        n_vec++; if (lat !== 1 || anx !== 1'b0) begin n_err++; $display("FAIL lat1_st: got lat=%0d next=%b required 1/0", lat, anx); end
        access(1, 1'b0, 32'h40, SZ_WORD, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (lat !== 1 || rd !== 32'h0BADCAFE) begin n_err++; $display("FAIL lat1_ld: got lat=%0d rdata=%h required 1/0badcafe", lat, rd); end
        access(2, 1'b1, 32'h44, SZ_HALF, 1'b0, 32'h00008001, lat, anx, rd, er);
        n_vec++; if (lat !== 15 || anx !== 1'b0) begin n_err++; $display("FAIL lat15_st: got lat=%0d next=%b required 15/0", lat, anx); end
        access(2, 1'b0, 32'h44, SZ_HALF, 1'b0, 32'd0, lat, anx, rd, er);
        n_vec++; if (lat !== 15 || rd !== 32'hFFFF8001) begin n_err++; $display("FAIL lat15_ld: got lat=%0d rdata=%h required 15/ffff8001", lat, rd); end
    endtask

    task automatic test_back_to_back;
        int acks; logic [31:0] first_rd;
        // Holding req through RESP must start a second access right after.
        we = 1'b0; addr = 32'h10; size = SZ_WORD; uns = 1'b0; wdata = 32'd0;
        req0 = 1'b1;
        acks = 0;
        first_rd = 32'd0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            if (ack0 === 1'b1) begin
                acks++;
                if (acks == 1) first_rd = rdata0;
            end
        end
        req0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (acks !== 2) begin n_err++; $display("FAIL b2b_acks: got %0d required 2", acks); end
        n_vec++; if (first_rd !== 32'h123455EF) begin n_err++; $display("FAIL b2b_rdata: got %h required 123455ef", first_rd); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_sub_word_load();
        test_sub_word_store();
        test_errors();
        test_range();
        test_reset_abort();
        test_latency_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
